// File: rtl/psx_mem_arbiter.sv
// -----------------------------------------------------------------------------
// psx_mem_arbiter
//   Two-client request arbiter and sequencer in front of the PSX-side DDR
//   bridge. Client A is the GPU render/VRAM path and client B is the CPU/DMA
//   path. Requests are serialised onto the bridge's command/busy interface with
//   one transaction in flight at a time. Read data is routed back to whichever
//   client issued the read.
//
// Build option:
//   PSXARB_FIXED_PRIO_EN  defined   : A always wins a tie; there is no
//                                     last-grant pointer.
//                         undefined : round-robin between A and B.
//
// Parameters:
//   WDOG_W  width of the per-transaction watchdog. A transaction is abandoned
//           after 2^WDOG_W-1 WAIT_DONE cycles. Must be 2 or more.
//
// Ports:
//   i_clk, i_nRst                 clock, async active-low reset
//   i_req*/i_write*/i_size*       client request, direction, size (0=8B,1=32B,2=4B)
//   i_adr*/i_sub*/i_mask*/i_data* block address, word sub-address, half-word mask, write data
//   o_ack*                        1-cycle pulse: request accepted
//   o_rdValid*                    1-cycle pulse: o_rdData belongs to that client
//   o_rdData                      read data, shared, direct from the bridge
//   o_timeout                     sticky watchdog error, cleared only by reset
//   o_command ... o_dataBridge    bridge command interface
//   i_busyBridge, i_dataValidBridge, i_dataBridge  bridge status and read return
// -----------------------------------------------------------------------------
// state        | meaning
// ST_IDLE      | waiting for a request while the bridge is idle; grant here
// ST_ISSUE     | command pulse and ack to the owner; watchdog cleared
// ST_WAIT_BUSY | one-cycle hole covering the bridge's registered busy
// ST_WAIT_DONE | write: wait busy low; read: wait data valid; watchdog runs
// -----------------------------------------------------------------------------
module psx_mem_arbiter #(
  parameter int WDOG_W = 10
) (
  input  logic         i_clk,
  input  logic         i_nRst,

  input  logic         i_reqA,
  input  logic         i_writeA,
  input  logic [1:0]   i_sizeA,
  input  logic [14:0]  i_adrA,
  input  logic [2:0]   i_subA,
  input  logic [15:0]  i_maskA,
  input  logic [255:0] i_dataA,
  output logic         o_ackA,
  output logic         o_rdValidA,

  input  logic         i_reqB,
  input  logic         i_writeB,
  input  logic [1:0]   i_sizeB,
  input  logic [14:0]  i_adrB,
  input  logic [2:0]   i_subB,
  input  logic [15:0]  i_maskB,
  input  logic [255:0] i_dataB,
  output logic         o_ackB,
  output logic         o_rdValidB,

  output logic [255:0] o_rdData,
  output logic         o_timeout,

  output logic         o_command,
  output logic         o_writeElseRead,
  output logic [1:0]   o_commandSize,
  output logic [14:0]  o_targetAddr,
  output logic [2:0]   o_subAddr,
  output logic [15:0]  o_writeMask,
  output logic [255:0] o_dataBridge,
  input  logic         i_busyBridge,
  input  logic         i_dataValidBridge,
  input  logic [255:0] i_dataBridge
);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_DONE = 2'd3
  } state_t;

  // Counter value one short of all-ones: the increment out of this value is
  // the one that reaches 2^WDOG_W-1 and trips the watchdog.
  localparam logic [WDOG_W-1:0] WDOG_LAST = {{(WDOG_W-1){1'b1}}, 1'b0};

  state_t            state;
  state_t            state_nxt;
  logic              owner_b;     // 0 = A owns the transaction, 1 = B
  logic [WDOG_W-1:0] wdog;
  logic              timeout_q;
  logic              grant;
  logic              grant_b;
  logic              done;
  logic              wdog_expire;

`ifndef PSXARB_FIXED_PRIO_EN
  logic              last_b;      // 1 = B had the most recent grant
`endif

  // ---------------------------------------------------------------------------
  // Arbitration and completion
  // ---------------------------------------------------------------------------
  always_comb begin
    grant = (state == ST_IDLE) && !i_busyBridge && (i_reqA || i_reqB);
`ifdef PSXARB_FIXED_PRIO_EN
    grant_b = !i_reqA;
`else
    // On a tie the client that did not win last time goes next.
    grant_b = i_reqB && (!i_reqA || !last_b);
`endif
    // The captured write flag decides which bridge event ends the transaction.
    done        = o_writeElseRead ? !i_busyBridge : i_dataValidBridge;
    wdog_expire = (wdog == WDOG_LAST);
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_nRst) begin
    if (!i_nRst) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:      if (grant) state_nxt = ST_ISSUE;
      ST_ISSUE:     state_nxt = ST_WAIT_BUSY;
      ST_WAIT_BUSY: state_nxt = ST_WAIT_DONE;
      ST_WAIT_DONE: if (done || wdog_expire) state_nxt = ST_IDLE;
      default:      state_nxt = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    o_command  = (state == ST_ISSUE);
    o_ackA     = (state == ST_ISSUE) && !owner_b;
    o_ackB     = (state == ST_ISSUE) &&  owner_b;
    // Zero-latency read return: valid goes straight through in WAIT_DONE.
    o_rdValidA = (state == ST_WAIT_DONE) && !o_writeElseRead && i_dataValidBridge && !owner_b;
    o_rdValidB = (state == ST_WAIT_DONE) && !o_writeElseRead && i_dataValidBridge &&  owner_b;
    o_timeout  = timeout_q;
  end

  assign o_rdData = i_dataBridge;

  // ---------------------------------------------------------------------------
  // Captured request fields, owner and round-robin pointer
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_nRst) begin
    if (!i_nRst) begin
      owner_b         <= 1'b0;
      o_writeElseRead <= 1'b0;
      o_commandSize   <= 2'd0;
      o_targetAddr    <= 15'd0;
      o_subAddr       <= 3'd0;
      o_writeMask     <= 16'd0;
      o_dataBridge    <= 256'd0;
`ifndef PSXARB_FIXED_PRIO_EN
      last_b          <= 1'b1;
`endif
    end else if (grant) begin
      owner_b         <= grant_b;
      o_writeElseRead <= grant_b ? i_writeB : i_writeA;
      o_commandSize   <= grant_b ? i_sizeB  : i_sizeA;
      o_targetAddr    <= grant_b ? i_adrB   : i_adrA;
      o_subAddr       <= grant_b ? i_subB   : i_subA;
      o_writeMask     <= grant_b ? i_maskB  : i_maskA;
      o_dataBridge    <= grant_b ? i_dataB  : i_dataA;
`ifndef PSXARB_FIXED_PRIO_EN
      last_b          <= grant_b;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Watchdog and sticky timeout flag
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_nRst) begin
    if (!i_nRst) begin
      wdog      <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (state == ST_ISSUE) begin
        wdog <= '0;
      end else if (state == ST_WAIT_DONE && !done) begin
        wdog <= wdog + WDOG_W'(1);
        if (wdog_expire) timeout_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_psx_mem_arbiter.sv
module tb_psx_mem_arbiter;

  logic         i_clk = 1'b0;
  logic         i_nRst = 1'b0;
  logic         i_reqA = 0, i_writeA = 0, i_reqB = 0, i_writeB = 0;
  logic [1:0]   i_sizeA = 0, i_sizeB = 0;
  logic [14:0]  i_adrA = 0, i_adrB = 0;
  logic [2:0]   i_subA = 0, i_subB = 0;
  logic [15:0]  i_maskA = 0, i_maskB = 0;
  logic [255:0] i_dataA = 0, i_dataB = 0;
  logic         o_ackA, o_ackB, o_rdValidA, o_rdValidB, o_timeout;
  logic [255:0] o_rdData;
  logic         o_command, o_writeElseRead;
  logic [1:0]   o_commandSize;
  logic [14:0]  o_targetAddr;
  logic [2:0]   o_subAddr;
  logic [15:0]  o_writeMask;
  logic [255:0] o_dataBridge;
  logic         i_busyBridge = 0, i_dataValidBridge = 0;
  logic [255:0] i_dataBridge = 0;

  psx_mem_arbiter #(.WDOG_W(4)) dut (
    .i_clk(i_clk), .i_nRst(i_nRst),
    .i_reqA(i_reqA), .i_writeA(i_writeA), .i_sizeA(i_sizeA), .i_adrA(i_adrA),
    .i_subA(i_subA), .i_maskA(i_maskA), .i_dataA(i_dataA),
    .o_ackA(o_ackA), .o_rdValidA(o_rdValidA),
    .i_reqB(i_reqB), .i_writeB(i_writeB), .i_sizeB(i_sizeB), .i_adrB(i_adrB),
    .i_subB(i_subB), .i_maskB(i_maskB), .i_dataB(i_dataB),
    .o_ackB(o_ackB), .o_rdValidB(o_rdValidB),
    .o_rdData(o_rdData), .o_timeout(o_timeout),
    .o_command(o_command), .o_writeElseRead(o_writeElseRead),
    .o_commandSize(o_commandSize), .o_targetAddr(o_targetAddr),
    .o_subAddr(o_subAddr), .o_writeMask(o_writeMask), .o_dataBridge(o_dataBridge),
    .i_busyBridge(i_busyBridge), .i_dataValidBridge(i_dataValidBridge),
    .i_dataBridge(i_dataBridge)
  );

  always #5 i_clk = ~i_clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Pulse counters, sampled mid-cycle.
  int m_ackA = 0, m_ackB = 0, m_rdA = 0, m_rdB = 0, m_cmd = 0;
  always @(negedge i_clk) begin
    if (o_ackA)     m_ackA++;
    if (o_ackB)     m_ackB++;
    if (o_rdValidA) m_rdA++;
    if (o_rdValidB) m_rdB++;
    if (o_command)  m_cmd++;
  end

  typedef struct {
    logic         cli;     // 0 = A, 1 = B
    logic         wr;
    logic [1:0]   size;
    logic [14:0]  adr;
    logic [2:0]   sub;
    logic [15:0]  mask;
    logic [255:0] data;    // write data, or data the bridge returns for a read
    int           lat;     // read: valid this many cycles after command; write: busy cycles
    logic         exp_ackA, exp_ackB, exp_rdA, exp_rdB;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic drive_req(input logic cli, input logic wr, input logic [1:0] size,
                           input logic [14:0] adr, input logic [2:0] sub,
                           input logic [15:0] mask, input logic [255:0] data);
    if (!cli) begin
      i_reqA = 1; i_writeA = wr; i_sizeA = size; i_adrA = adr;
      i_subA = sub; i_maskA = mask; i_dataA = data;
    end else begin
      i_reqB = 1; i_writeB = wr; i_sizeB = size; i_adrB = adr;
      i_subB = sub; i_maskB = mask; i_dataB = data;
    end
  endtask

  // Waits (bounded) for an ack; n returns the number of ticks taken.
  task automatic wait_ack(output bit got, output int n);
    got = 0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge i_clk);
      if (o_ackA || o_ackB) begin
        got = 1;
        n = i;
        break;
      end
      tick();
    end
  endtask

  // Called at the start of an IDLE cycle; returns at the start of the next IDLE cycle.
  task automatic run_txn(input string tag, input vec_t v);
    int a0, b0, ra0, rb0, c0, n, endk;
    bit got;
    a0 = m_ackA; b0 = m_ackB; ra0 = m_rdA; rb0 = m_rdB; c0 = m_cmd;
    drive_req(v.cli, v.wr, v.size, v.adr, v.sub, v.mask, v.data);
    wait_ack(got, n);
    chk({tag, " ack_seen"}, 256'(got), 256'(1));
    if (!got) begin
      i_reqA = 0; i_reqB = 0;
      return;
    end
    chk({tag, " ack_latency"}, 256'(n), 256'(1));
    chk({tag, " ackA"}, 256'(o_ackA), 256'(v.exp_ackA));
    chk({tag, " ackB"}, 256'(o_ackB), 256'(v.exp_ackB));
    chk({tag, " command"}, 256'(o_command), 256'(1));
    chk({tag, " write"}, 256'(o_writeElseRead), 256'(v.wr));
    chk({tag, " size"}, 256'(o_commandSize), 256'(v.size));
    chk({tag, " addr"}, 256'(o_targetAddr), 256'(v.adr));
    chk({tag, " sub"}, 256'(o_subAddr), 256'(v.sub));
    chk({tag, " mask"}, 256'(o_writeMask), 256'(v.mask));
    chk({tag, " wdata"}, o_dataBridge, v.data);
    tick();
    i_reqA = 0; i_reqB = 0;
    endk = v.wr ? ((v.lat + 1 < 2) ? 2 : v.lat + 1) : v.lat;
    for (int k = 1; k <= endk; k++) begin
      if (k > 1) tick();
      if (v.wr) i_busyBridge = (k <= v.lat);
      // Writes also see a valid pulse, which must not produce rdValid.
      i_dataValidBridge = (k == endk);
      i_dataBridge      = (k == endk) ? v.data : 256'd0;
      @(negedge i_clk);
      if (k == endk) begin
        chk({tag, " rdValidA"}, 256'(o_rdValidA), 256'(v.exp_rdA));
        chk({tag, " rdValidB"}, 256'(o_rdValidB), 256'(v.exp_rdB));
        if (!v.wr) chk({tag, " rdData"}, o_rdData, v.data);
      end
    end
    tick();
    i_busyBridge = 0; i_dataValidBridge = 0; i_dataBridge = 0;
    chk({tag, " ackA_count"}, 256'(m_ackA - a0), 256'(v.exp_ackA));
    chk({tag, " ackB_count"}, 256'(m_ackB - b0), 256'(v.exp_ackB));
    chk({tag, " rdA_count"}, 256'(m_rdA - ra0), 256'(v.exp_rdA));
    chk({tag, " rdB_count"}, 256'(m_rdB - rb0), 256'(v.exp_rdB));
    chk({tag, " cmd_count"}, 256'(m_cmd - c0), 256'(1));
  endtask

  initial begin
    int n, c0, b0, ra0, rb0;
    bit got;
    bit exp_own[4];
    vec_t wv;

`ifdef PSXARB_FIXED_PRIO_EN
    exp_own = '{1'b0, 1'b0, 1'b0, 1'b0};
`else
    exp_own = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif

    //          cli wr size adr       sub mask      data                       lat ackA ackB rdA rdB
    vecs[0] = '{1'b0, 1'b0, 2'd1, 15'h1234, 3'd0, 16'h0000, {8{32'hDEAD_BEEF}}, 5, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 2'd2, 15'h0010, 3'd1, 16'h0003, {8{32'h0BAD_F00D}}, 3, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 2'd1, 15'h0000, 3'd0, 16'hFFFF, {16{16'hA5C3}},     1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 2'd0, 15'h7FFF, 3'd7, 16'h0000, {4{64'h0123_4567_89AB_CDEF}}, 2, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{1'b0, 1'b0, 2'd2, 15'h4000, 3'd3, 16'h0000, {2{128'hFEDC_BA98_7654_3210_0F1E_2D3C_4B5A_6978}}, 3, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 2'd1, 15'h2AAA, 3'd5, 16'h0000, {32{8'h5A}},        4, 1'b0, 1'b1, 1'b0, 1'b1};

    // Reset state
    #2;
    chk("rst command", 256'(o_command), 256'(0));
    chk("rst acks", 256'({o_ackA, o_ackB}), 256'(0));
    chk("rst rdValid", 256'({o_rdValidA, o_rdValidB}), 256'(0));
    chk("rst timeout", 256'(o_timeout), 256'(0));
    chk("rst fields", 256'({o_writeElseRead, o_commandSize, o_targetAddr, o_subAddr, o_writeMask}), 256'(0));
    chk("rst wdata", o_dataBridge, 256'd0);
    @(posedge i_clk); tick();
    i_nRst = 1;
    tick();

    // Request blocked by busy bridge, then withdrawn: no side effect
    c0 = m_cmd; b0 = m_ackB;
    i_busyBridge = 1;
    drive_req(1'b1, 1'b0, 2'd0, 15'h0055, 3'd2, 16'h0000, 256'd0);
    tick(); tick(); tick();
    i_reqB = 0;
    tick();
    i_busyBridge = 0;
    tick(); tick(); tick();
    chk("drop ackB_count", 256'(m_ackB - b0), 256'(0));
    chk("drop cmd_count", 256'(m_cmd - c0), 256'(0));

    // Directed single-client transactions
    for (int i = 0; i < 6; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      run_txn(tag, vecs[i]);
    end

    // Both clients hold read requests continuously
    drive_req(1'b0, 1'b0, 2'd1, 15'h0AAA, 3'd0, 16'h0000, 256'd0);
    drive_req(1'b1, 1'b0, 2'd0, 15'h0BBB, 3'd4, 16'h0000, 256'd0);
    for (int g = 0; g < 4; g++) begin
      wait_ack(got, n);
      chk($sformatf("tie%0d ack_seen", g), 256'(got), 256'(1));
      chk($sformatf("tie%0d spacing", g), 256'(n), 256'(1));
      chk($sformatf("tie%0d owner", g), 256'(o_ackB), 256'(exp_own[g]));
      chk($sformatf("tie%0d addr", g), 256'(o_targetAddr), exp_own[g] ? 256'(15'h0BBB) : 256'(15'h0AAA));
      tick();
      tick();
      i_dataValidBridge = 1;
      i_dataBridge = {8{32'h1000_0000 + g}};
      if (g == 3) i_reqA = 0;
      @(negedge i_clk);
      chk($sformatf("tie%0d rdValidA", g), 256'(o_rdValidA), 256'(!exp_own[g]));
      chk($sformatf("tie%0d rdValidB", g), 256'(o_rdValidB), 256'(exp_own[g]));
      chk($sformatf("tie%0d rdData", g), o_rdData, {8{32'h1000_0000 + g}});
      tick();
      i_dataValidBridge = 0;
    end
    wait_ack(got, n);
    chk("tie_end ack_seen", 256'(got), 256'(1));
    chk("tie_end latency", 256'(n), 256'(1));
    chk("tie_end ackB", 256'(o_ackB), 256'(1));
    tick();
    i_reqB = 0;
    tick();
    i_dataValidBridge = 1;
    i_dataBridge = {8{32'hCAFE_0B0B}};
    @(negedge i_clk);
    chk("tie_end rdValidB", 256'(o_rdValidB), 256'(1));
    chk("tie_end rdValidA", 256'(o_rdValidA), 256'(0));
    tick();
    i_dataValidBridge = 0;

    // Watchdog: read with no bridge response (WDOG_W=4 -> 15 WAIT_DONE cycles)
    ra0 = m_rdA; rb0 = m_rdB;
    drive_req(1'b0, 1'b0, 2'd1, 15'h0123, 3'd0, 16'h0000, 256'd0);
    wait_ack(got, n);
    chk("wdog ack_seen", 256'(got), 256'(1));
    tick();
    i_reqA = 0;
    for (int k = 2; k <= 17; k++) begin
      tick();
      if (k == 17) begin
        i_dataValidBridge = 1;
        i_dataBridge = {8{32'h7777_7777}};
      end
      @(negedge i_clk);
      if (k == 16) chk("wdog not_yet", 256'(o_timeout), 256'(0));
      if (k == 17) begin
        chk("wdog timeout", 256'(o_timeout), 256'(1));
        chk("wdog stray_valid", 256'(o_rdValidA), 256'(0));
      end
    end
    tick();
    i_dataValidBridge = 0;
    chk("wdog rd_count", 256'(m_rdA - ra0 + m_rdB - rb0), 256'(0));
    wv = '{1'b1, 1'b1, 2'd0, 15'h0321, 3'd6, 16'h00F0, {8{32'h1357_9BDF}}, 2, 1'b0, 1'b1, 1'b0, 1'b0};
    run_txn("post_wdog", wv);
    chk("wdog sticky", 256'(o_timeout), 256'(1));

    // Reset in the middle of a read's WAIT_DONE
    drive_req(1'b0, 1'b0, 2'd2, 15'h6789, 3'd2, 16'h0000, {8{32'h2468_ACE0}});
    wait_ack(got, n);
    chk("mrst ack_seen", 256'(got), 256'(1));
    tick();
    i_reqA = 0;
    tick();
    tick();
    i_nRst = 0;
    #1;
    chk("mrst command", 256'(o_command), 256'(0));
    chk("mrst acks", 256'({o_ackA, o_ackB}), 256'(0));
    chk("mrst timeout", 256'(o_timeout), 256'(0));
    chk("mrst fields", 256'({o_writeElseRead, o_commandSize, o_targetAddr, o_subAddr, o_writeMask}), 256'(0));
    chk("mrst wdata", o_dataBridge, 256'd0);
    tick();
    tick();
    i_nRst = 1;
    tick();
    i_dataValidBridge = 1;
    i_dataBridge = {8{32'h9999_9999}};
    @(negedge i_clk);
    chk("mrst stray rdValid", 256'({o_rdValidA, o_rdValidB}), 256'(0));
    tick();
    i_dataValidBridge = 0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, got hang expected finish");
    $fatal(1);
  end

endmodule

// File: doc/psx_mem_arbiter.md
Name: psx_mem_arbiter

Overview:
- Two-client request arbiter and sequencer directly upstream of the PSX-side DDR bridge.
- Accepts 4/8/32-byte read and write requests from client A (GPU render/VRAM path) and client B (CPU/DMA transfer path).
- Serialises them onto the bridge's single command/busy interface, one transaction in flight at a time.
- Routes returned read data to the client that issued the request.

Parameters:
- WDOG_W, 10: width of the per-transaction watchdog counter. Timeout occurs at 2^WDOG_W-1 wait cycles.

Ports:
- i_clk  in  1  clock
- i_nRst  in  1  asynchronous active-low reset
- i_reqA / i_reqB  in  1  request valid; held, with fields stable, until ack
- i_writeA / i_writeB  in  1  1=write, 0=read
- i_sizeA / i_sizeB  in  2  0=8 byte, 1=32 byte, 2=4 byte
- i_adrA / i_adrB  in  15  32-byte block address
- i_subA / i_subB  in  3  4-byte word sub-address
- i_maskA / i_maskB  in  16  write mask, 1 bit per 16-bit half-word
- i_dataA / i_dataB  in  256  write data
- o_ackA / o_ackB  out  1  one-cycle pulse: request accepted, fields captured
- o_rdValidA / o_rdValidB  out  1  one-cycle pulse: o_rdData valid for that client
- o_rdData  out  256  read data, shared by both clients
- o_timeout  out  1  sticky watchdog error flag
- o_command  out  1  bridge command pulse
- o_writeElseRead  out  1  to bridge
- o_commandSize  out  2  to bridge
- o_targetAddr  out  15  to bridge
- o_subAddr  out  3  to bridge
- o_writeMask  out  16  to bridge
- o_dataBridge  out  256  to bridge
- i_busyBridge  in  1  bridge busy
- i_dataValidBridge  in  1  bridge read data valid
- i_dataBridge  in  256  bridge read data

Behaviour:
- Reset (async assert, sync release):
  - FSM to IDLE.
  - All outputs 0.
  - Owner register = A; last-grant pointer = B, so A wins the first tie.
  - o_timeout cleared. Reset is the only clear for o_timeout.
- FSM states: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
- IDLE:
  - Grant when i_busyBridge==0 and any req is asserted.
  - Capture the winner's write/size/adr/sub/mask/data into output registers.
  - Record the owner and the write flag; go to ISSUE.
- ISSUE (exactly 1 cycle):
  - o_command=1 and o_ack<owner>=1.
  - Clear the watchdog counter; go to WAIT_BUSY.
- WAIT_BUSY (exactly 1 cycle): covers the bridge's registered busy; i_busyBridge is ignored here. Go to WAIT_DONE.
- WAIT_DONE, write: i_busyBridge==0 ends the transaction; go to IDLE.
- WAIT_DONE, read:
  - i_dataValidBridge==1 ends the transaction.
  - That same cycle (combinational, zero latency): o_rdData=i_dataBridge and o_rdValid<owner>=1. Go to IDLE.
- Bridge fields (o_targetAddr etc.) hold their captured values from ISSUE until the next grant.
- o_rdData is driven from i_dataBridge at all times. It is meaningful only with o_rdValid.
- i_dataValidBridge is ignored outside WAIT_DONE-read; no o_rdValid is produced.
- Throughput: one transaction per 4 cycles minimum (IDLE, ISSUE, WAIT_BUSY, WAIT_DONE). The next grant is evaluated on the first IDLE cycle.
- Arbitration (default, round-robin):
  - Single requester wins.
  - Both requesting: the client not in the last-grant pointer wins.
  - The pointer updates on each grant.
- Client request rules:
  - A request deasserted before ack is dropped without side effect.
  - A client may reassert req on the cycle after its ack.
- Watchdog:
  - Counter increments every WAIT_DONE cycle.
  - On reaching 2^WDOG_W-1: set o_timeout, abandon the transaction (no o_rdValid), return to IDLE.
  - Normal arbitration continues after a timeout.
- Simultaneous events: a request arriving in the same cycle as completion waits for the next IDLE cycle.

Optional Feature:
- Macro: PSXARB_FIXED_PRIO_EN.
- Defined: client A always wins when both request; the last-grant pointer is unused and removed.
- Undefined: round-robin as above.

Test Plan:
- Reset, then A read 32-byte adr=0x1234 sub=0, bridge valid 5 cycles after command with data D -> exactly one o_ackA; o_command high 1 cycle with o_targetAddr=0x1234, o_commandSize=1; o_rdValidA=1 with o_rdData=D; o_rdValidB stays 0.
- B write 4-byte adr=0x0010 sub=1 mask=0x0003, bridge busy 3 cycles -> o_writeMask=0x0003, o_subAddr=1 at command; back in IDLE on first busy-low cycle; no rdValid pulses.
- A and B both hold read requests continuously (round-robin build) -> grants alternate A,B,A,B; each o_ack matches its following o_rdValid owner.
- Same stimulus with PSXARB_FIXED_PRIO_EN -> only A granted while A requests; B granted on the first IDLE cycle after A deasserts.
- WDOG_W=4, read issued, bridge never returns valid -> o_timeout=1 after 15 WAIT_DONE cycles; FSM in IDLE; a following B write completes normally; o_timeout stays 1.
- Assert i_nRst=0 mid-WAIT_DONE read, then release, then bridge valid pulse -> all outputs 0 immediately on assertion; the stray valid produces no o_rdValid.
